// File: rtl/bootrom_obi_arbiter.sv
// Two-port OBI arbiter in front of a single-ported boot ROM; illegal accesses are answered locally with an error.
// Optional macro BOOTROM_ARB_ROUND_ROBIN_EN switches tie-breaking from fixed priority to round-robin.
module bootrom_obi_arbiter #(
    parameter int Depth        = 42,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = $clog2(Depth * 4)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    p0_req_i,
    input  logic [31:0]             p0_addr_i,
    input  logic                    p0_we_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    output logic [DataWidth-1:0]    p0_rdata_o,
    output logic                    p0_err_o,
    input  logic                    p1_req_i,
    input  logic [31:0]             p1_addr_i,
    input  logic                    p1_we_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    output logic [DataWidth-1:0]    p1_rdata_o,
    output logic                    p1_err_o,
    output logic                    bootrom_req_o,
    output logic [AddressWidth-1:0] bootrom_addr_o,
    input  logic [DataWidth-1:0]    bootrom_rdata_i
);

    // Writes, misaligned and out-of-range addresses must never reach the ROM.
    function automatic logic access_err(input logic we, input logic [31:0] addr);
        logic [31:0] word_idx;
        word_idx   = 32'(addr[AddressWidth-1:2]);
        access_err = we | (addr[1:0] != 2'b00) | (word_idx >= 32'(Depth))
                   | (addr[31:AddressWidth] != '0);
    endfunction

    logic        tie_pick1;
    logic        gnt0, gnt1, any_gnt;
    logic [31:0] sel_addr;
    logic        sel_we, sel_err;
    logic        resp_valid_q, resp_port_q, resp_err_q;

`ifdef BOOTROM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // On a tie, serve the port that did not win the most recent grant.
    assign tie_pick1 = ~last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (any_gnt) begin
            last_q <= gnt1;
        end
    end
`else
    assign tie_pick1 = 1'b0;
`endif

    // Request stage: arbitration and classification, all combinational.
    assign gnt1    = rst_ni & p1_req_i & (~p0_req_i | tie_pick1);
    assign gnt0    = rst_ni & p0_req_i & (~p1_req_i | ~tie_pick1);
    assign any_gnt = gnt0 | gnt1;

    assign sel_addr = gnt1 ? p1_addr_i : p0_addr_i;
    assign sel_we   = gnt1 ? p1_we_i   : p0_we_i;
    assign sel_err  = access_err(sel_we, sel_addr);

    assign p0_gnt_o       = gnt0;
    assign p1_gnt_o       = gnt1;
    assign bootrom_req_o  = any_gnt & ~sel_err;
    assign bootrom_addr_o = bootrom_req_o ? sel_addr[AddressWidth-1:0] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= any_gnt;
            resp_port_q  <= gnt1;
            resp_err_q   <= any_gnt & sel_err;
        end
    end

    // Response stage: route ROM data or the error to the port granted last cycle.
    assign p0_rvalid_o = resp_valid_q & ~resp_port_q;
    assign p1_rvalid_o = resp_valid_q & resp_port_q;
    assign p0_err_o    = p0_rvalid_o & resp_err_q;
    assign p1_err_o    = p1_rvalid_o & resp_err_q;
    assign p0_rdata_o  = (p0_rvalid_o & ~resp_err_q) ? bootrom_rdata_i : '0;
    assign p1_rdata_o  = (p1_rvalid_o & ~resp_err_q) ? bootrom_rdata_i : '0;

endmodule

// File: tb/tb_bootrom_obi_arbiter.sv
// Directed plus randomized bench for bootrom_obi_arbiter against a transaction-level reference model.
module tb_bootrom_obi_arbiter;
    localparam int Depth = 42;
    localparam int DW    = 32;
    localparam int AW    = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          p0_req_i = 1'b0, p1_req_i = 1'b0;
    logic [31:0]   p0_addr_i = '0, p1_addr_i = '0;
    logic          p0_we_i = 1'b0, p1_we_i = 1'b0;
    logic          p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, p0_err_o, p1_err_o;
    logic [DW-1:0] p0_rdata_o, p1_rdata_o;
    logic          bootrom_req_o;
    logic [AW-1:0] bootrom_addr_o;
    logic [DW-1:0] bootrom_rdata_i = '0;

    int n_chk  = 0;
    int n_pass = 0;
    int last_won = 1;  // model: port that received the most recent grant

    bootrom_obi_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i),
        .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o), .p0_err_o(p0_err_o),
        .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
        .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o), .p1_err_o(p1_err_o),
        .bootrom_req_o(bootrom_req_o), .bootrom_addr_o(bootrom_addr_o),
        .bootrom_rdata_i(bootrom_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rom_word(input int idx);
        return 32'hC0DE_0000 ^ (32'(idx) * 32'h0001_0F1F) ^ 32'(idx);
    endfunction

    // Behavioural ROM: registered read, holds its output when not requested.
    always @(posedge clk_i) begin
        if (bootrom_req_o) bootrom_rdata_i <= rom_word(int'(bootrom_addr_o) / 4);
    end

    function automatic bit model_err(input bit we, input logic [31:0] a);
        return we || (a % 4 != 0) || (a >= 32'(Depth * 4));
    endfunction

    function automatic int model_winner(input bit r0, input bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (!r0 && !r1) return -1;
`ifdef BOOTROM_ARB_ROUND_ROBIN_EN
        return (last_won == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return 32'($urandom_range(0, Depth - 1)) * 4;
            3:       return 32'($urandom_range(0, Depth - 1)) * 4 + 32'($urandom_range(1, 3));
            4:       return 32'($urandom_range(Depth, 63)) * 4;
            default: return (32'h1 << $urandom_range(8, 31)) | (32'($urandom_range(0, Depth - 1)) * 4);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"}, 32'(p0_gnt_o), 0);
        chk({tag, "_gnt1"}, 32'(p1_gnt_o), 0);
        chk({tag, "_rv0"}, 32'(p0_rvalid_o), 0);
        chk({tag, "_rv1"}, 32'(p1_rvalid_o), 0);
        chk({tag, "_err0"}, 32'(p0_err_o), 0);
        chk({tag, "_err1"}, 32'(p1_err_o), 0);
        chk({tag, "_rd0"}, p0_rdata_o, 0);
        chk({tag, "_rd1"}, p1_rdata_o, 0);
        chk({tag, "_rreq"}, 32'(bootrom_req_o), 0);
        chk({tag, "_raddr"}, 32'(bootrom_addr_o), 0);
    endtask

    // One bus cycle: drive at negedge, check grant side, then check response after the edge.
    task automatic do_cycle(input string tag, input bit r0, input logic [31:0] a0, input bit w0,
                            input bit r1, input logic [31:0] a1, input bit w1, output int won);
        logic [31:0] ga, data;
        bit ge;
        @(negedge clk_i);
        p0_req_i = r0; p0_addr_i = a0; p0_we_i = w0;
        p1_req_i = r1; p1_addr_i = a1; p1_we_i = w1;
        #1;
        won  = model_winner(r0, r1);
        ga   = (won == 1) ? a1 : a0;
        ge   = (won == 1) ? model_err(w1, a1) : model_err(w0, a0);
        data = ge ? 32'h0 : rom_word(int'(ga / 4));
        chk({tag, "_gnt0"}, 32'(p0_gnt_o), 32'(won == 0));
        chk({tag, "_gnt1"}, 32'(p1_gnt_o), 32'(won == 1));
        chk({tag, "_rreq"}, 32'(bootrom_req_o), 32'(won >= 0 && !ge));
        if (won >= 0 && !ge) chk({tag, "_raddr"}, 32'(bootrom_addr_o), ga % 256);
        if (won >= 0) last_won = won;
        @(posedge clk_i);
        #1;
        chk({tag, "_rv0"}, 32'(p0_rvalid_o), 32'(won == 0));
        chk({tag, "_rv1"}, 32'(p1_rvalid_o), 32'(won == 1));
        chk({tag, "_err0"}, 32'(p0_err_o), 32'(won == 0 && ge));
        chk({tag, "_err1"}, 32'(p1_err_o), 32'(won == 1 && ge));
        chk({tag, "_rd0"}, p0_rdata_o, (won == 0) ? data : 32'h0);
        chk({tag, "_rd1"}, p1_rdata_o, (won == 1) ? data : 32'h0);
    endtask

    initial begin
        int won;
        int tie_w[4];
        bit r0, r1, w0, w1, hold0, hold1;
        logic [31:0] a0, a1;

        // Reset with requests pending: every output must read 0.
        p0_req_i = 1'b1; p1_req_i = 1'b1; p1_addr_i = 32'h4;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");
        p0_req_i = 1'b0; p1_req_i = 1'b0;
        rst_ni = 1'b1;
        last_won = 1;

        do_cycle("idle", 0, 0, 0, 0, 0, 0, won);
        do_cycle("p0_rd0", 1, 32'h000, 0, 0, 0, 0, won);
        do_cycle("p0_rd4", 1, 32'h004, 0, 0, 0, 0, won);
        do_cycle("p1_last", 0, 0, 0, 1, 32'h0A4, 0, won);
        do_cycle("p1_oor", 0, 0, 0, 1, 32'h0A8, 0, won);
        do_cycle("p0_wr", 1, 32'h010, 1, 0, 0, 0, won);
        do_cycle("p1_mis", 0, 0, 0, 1, 32'h012, 0, won);

        for (int i = 0; i < 4; i++) begin
            do_cycle($sformatf("tie%0d", i), 1, 32'h020 + 32'(4 * i), 0, 1, 32'h024, 0, won);
            tie_w[i] = won;
        end
`ifdef BOOTROM_ARB_ROUND_ROBIN_EN
        chk("tie_pattern", {8'(tie_w[0]), 8'(tie_w[1]), 8'(tie_w[2]), 8'(tie_w[3])}, 32'h0001_0001);
`else
        chk("tie_pattern", {8'(tie_w[0]), 8'(tie_w[1]), 8'(tie_w[2]), 8'(tie_w[3])}, 32'h0000_0000);
`endif
        do_cycle("p1_after_tie", 0, 0, 0, 1, 32'h024, 0, won);

        // Reset right after a grant edge discards the pending response.
        @(negedge clk_i);
        p0_req_i = 1'b1; p0_addr_i = 32'h008; p0_we_i = 1'b0;
        p1_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk_i);
        p0_req_i = 1'b0;
        rst_ni = 1'b1;
        last_won = 1;
        do_cycle("post_rst_idle", 0, 0, 0, 0, 0, 0, won);
        do_cycle("post_rst_p1", 0, 0, 0, 1, 32'h008, 0, won);
        do_cycle("p0_upper", 1, 32'h8000_0000, 0, 0, 0, 0, won);

        // Randomized traffic; a losing port holds its request until granted.
        hold0 = 0; hold1 = 0;
        r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold0) begin
                r0 = ($urandom_range(0, 3) != 0);
                a0 = rand_addr();
                w0 = ($urandom_range(0, 7) == 0);
            end
            if (!hold1) begin
                r1 = ($urandom_range(0, 3) != 0);
                a1 = rand_addr();
                w1 = ($urandom_range(0, 7) == 0);
            end
            do_cycle("rand", r0, a0, w0, r1, a1, w1, won);
            hold0 = r0 && (won != 0);
            hold1 = r1 && (won != 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bootrom_obi_arbiter.md
Name: bootrom_obi_arbiter

Overview:
- Shares the single-ported boot ROM between two OBI-style requesters: port 0 (core instruction fetch) and port 1 (core data / debug loader).
- Sits between the core bus and the boot ROM. Grants at most one request per cycle and forwards it to the ROM's req/addr interface.
- Returns read data on the next cycle, routed to the granted port.
- Rejects writes, misaligned accesses and out-of-range addresses with an error response; these never reach the ROM.

Parameters:
- Depth, 42, number of 32-bit ROM words.
- DataWidth, 32, ROM word width.
- AddressWidth, $clog2(Depth*4), ROM byte-address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- p0_req_i  in  1  port 0 request.
- p0_addr_i  in  32  port 0 byte address.
- p0_we_i  in  1  port 0 write enable.
- p0_gnt_o  out  1  port 0 grant (combinational).
- p0_rvalid_o  out  1  port 0 response valid.
- p0_rdata_o  out  DataWidth  port 0 read data.
- p0_err_o  out  1  port 0 error (qualified by rvalid).
- p1_req_i, p1_addr_i, p1_we_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o: same as port 0, for port 1.
- bootrom_req_o  out  1  ROM request.
- bootrom_addr_o  out  AddressWidth  ROM byte address = granted addr[AddressWidth-1:0].
- bootrom_rdata_i  in  DataWidth  ROM data, valid the cycle after bootrom_req_o.

Behaviour:
- Reset: all outputs are 0 while rst_ni=0. The response pipeline register (resp_valid_q, resp_port_q, resp_err_q) clears asynchronously.
- Arbitration (combinational, single cycle):
  - Only one requesting: that port is granted.
  - Both requesting: fixed priority, port 0 wins. See optional feature for round-robin.
  - The losing port's gnt stays 0; it must hold req/addr/we stable until granted (OBI rule).
- Access classification on grant:
  - err = we | (addr[1:0] != 0) | (addr[AddressWidth-1:2] >= Depth) | (addr[31:AddressWidth] != 0).
  - Legal access (err=0): bootrom_req_o=1, bootrom_addr_o=addr[AddressWidth-1:0].
  - Erroneous access: bootrom_req_o=0. The ROM is not touched and keeps its previous registered address.
- Response:
  - Exactly one cycle after grant, rvalid=1 on the granted port only, for exactly one cycle.
  - err=0: rdata = bootrom_rdata_i, err=0.
  - err=1: rdata=0, err=1.
  - Non-addressed port: rvalid=0, rdata=0, err=0.
- Throughput: fully pipelined, one grant per cycle. Back-to-back grants to either port are allowed and there is no stall on response.
- Ordering: responses return in grant order. There is never more than one outstanding response.
- No request in a cycle: bootrom_req_o=0 and resp_valid_q is 0 the next cycle.
- Reset asserted mid-transaction: the pending response is discarded. No rvalid appears after rst_ni deasserts.

Optional Feature:
- Macro: BOOTROM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Adds a 1-bit register last_q, reset to 1 so port 0 wins the first tie.
  - On a tie, the port not equal to last_q is granted.
  - last_q updates to the granted port on every grant, including error grants.
- Undefined: fixed priority, port 0 always wins ties, and no last_q register exists.

Test Plan:
- Port 0 reads addr 0x000, then 0x004 back-to-back -> p0_gnt_o=1 in both cycles; p0_rvalid_o=1 in the following two cycles, with rdata = ROM word 0 then word 1; p0_err_o=0.
- Port 1 reads addr 0xA4 (word 41, the last) -> rvalid next cycle, err=0. Port 1 reads addr 0xA8 (word 42) -> bootrom_req_o=0, rvalid next cycle, err=1, rdata=0.
- Port 0 writes 0x010; port 1 reads 0x012 (misaligned) -> both return err=1, rdata=0; bootrom_req_o stays 0 in both cycles.
- Both ports request continuously for 4 cycles:
  - Without macro: p0 is granted 4 times and p1_gnt_o=0 throughout.
  - With BOOTROM_ARB_ROUND_ROBIN_EN: grants alternate p0, p1, p0, p1.
- Assert rst_ni=0 in the cycle after a grant -> no rvalid on either port, all outputs 0. After release, a port 1 read of 0x008 returns word 2 one cycle after grant.
- Port 0 read with p0_addr_i = 0x8000_0000 (upper bits set) -> err=1, and the ROM is not accessed.
